// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI3 constants for full-line write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [3:0] c_axi_len_line   = 4'd3;
    localparam logic [2:0] c_axi_size_word  = 3'b010;
    localparam logic [1:0] c_axi_burst_incr = 2'b01;
    localparam logic [3:0] c_axi_strb_full  = 4'hF;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared DCache line types and geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int c_word_w        = 32;
    localparam int c_line_words    = 4;
    localparam int c_line_offset_w = 4;

    typedef logic [c_word_w-1:0] word_t;
    typedef word_t [c_line_words-1:0] DCData_t;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_writeback.sv
`default_nettype none
// ============================================================================
// Module      : dcache_writeback
// Description : Dirty-line FIFO that drains evicted lines as AXI3 INCR bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_writeback
    import dcache_pkg::*;
    import axi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          push_valid,
    input  logic [31:0]   push_addr,
    input  DCData_t       push_data,
    output logic          push_ready,

    input  logic [31:0]   chk_addr,
    output logic          chk_hit,

    output logic          empty,

    output logic          awvalid,
    input  logic          awready,
    output logic [31:0]   awaddr,
    output logic [3:0]    awlen,
    output logic [2:0]    awsize,
    output logic [1:0]    awburst,

    output logic          wvalid,
    input  logic          wready,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic          wlast,

    input  logic          bvalid,
    output logic          bready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_tag_w = 32 - c_line_offset_w;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_tag_w-1:0]   r_tag  [DEPTH];
    DCData_t              r_data [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;
    logic [1:0]           r_beat;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_unused;

    // Only the line tag is kept; offset bits never reach the bus.
    assign w_unused = ^{push_addr[c_line_offset_w-1:0], chk_addr[c_line_offset_w-1:0]};

    assign w_push = push_valid && !rst && (r_count < c_depth);
    assign w_pop  = (r_state == ST_B) && bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_tail           <= r_tail + c_ptr_w'(1);
                r_valid[r_tail]  <= 1'b1;
            end
            // Head stays valid through B so refills keep seeing the line.
            if (w_pop) begin
                r_head           <= r_head + c_ptr_w'(1);
                r_valid[r_head]  <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if ((r_state == ST_W) && wready) begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_tail]  <= push_addr[31:c_line_offset_w];
            r_data[r_tail] <= push_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_count != '0)             w_state_nxt = ST_AW;
            ST_AW:   if (awready)                   w_state_nxt = ST_W;
            ST_W:    if (wready && r_beat == 2'd3)  w_state_nxt = ST_B;
            ST_B:    if (bvalid)                    w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == chk_addr[31:c_line_offset_w])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign push_ready = rst || (r_count < c_depth);
    assign empty      = rst || ((r_count == '0) && (r_state == ST_IDLE));
    assign chk_hit    = w_hit && !rst;

    assign awvalid = !rst && (r_state == ST_AW);
    assign awaddr  = awvalid ? {r_tag[r_head], {c_line_offset_w{1'b0}}} : 32'd0;
    assign awlen   = c_axi_len_line;
    assign awsize  = c_axi_size_word;
    assign awburst = c_axi_burst_incr;

    assign wvalid  = !rst && (r_state == ST_W);
    assign wdata   = wvalid ? r_data[r_head][r_beat] : 32'd0;
    assign wstrb   = c_axi_strb_full;
    assign wlast   = wvalid && (r_beat == 2'd3);

    assign bready  = !rst && (r_state == ST_B);

endmodule : dcache_writeback
`default_nettype wire

// File: tb/tb_dcache_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_writeback
// Description : Scoreboard bench for dcache_writeback with a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_writeback;
    import dcache_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready;
    logic [31:0] push_addr;
    DCData_t     push_data;
    logic [31:0] chk_addr;
    logic        chk_hit, empty;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;

    dcache_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
        .push_ready(push_ready),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        DCData_t     data;
    } line_t;

    // Lines accepted but not yet acknowledged, oldest first.
    line_t       mq[$];
    int          tb_phase;   // 0 await AW, 1 data beats, 2 await B
    int          tb_beat;
    int          total = 0;
    int          bad   = 0;
    logic        push_fired;
    logic        prev_aw_stall, prev_w_stall;
    logic [31:0] prev_awaddr, prev_wdata;
    logic        prev_wlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].addr[31:4] == a[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: compare at negedge, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_awvalid", 32'(awvalid), 32'd0);
            chk("rst_wvalid", 32'(wvalid), 32'd0);
            chk("rst_bready", 32'(bready), 32'd0);
            chk("rst_push_ready", 32'(push_ready), 32'd1);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_chk_hit", 32'(chk_hit), 32'd0);
            mq.delete();
            tb_phase = 0; tb_beat = 0;
            push_fired = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
        end else begin
            chk("push_ready", 32'(push_ready), 32'(mq.size() < DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("chk_hit", 32'(chk_hit), 32'(model_hit(chk_addr)));
            chk("wvalid_phase", 32'(wvalid), 32'(tb_phase == 1));
            chk("bready_phase", 32'(bready), 32'(tb_phase == 2));
            if (prev_aw_stall) begin
                chk("aw_hold_valid", 32'(awvalid), 32'd1);
                chk("aw_hold_addr", awaddr, prev_awaddr);
            end
            if (prev_w_stall) begin
                chk("w_hold_data", wdata, prev_wdata);
                chk("w_hold_last", 32'(wlast), 32'(prev_wlast));
            end
            if (awvalid) begin
                chk("aw_when_pending", 32'(tb_phase == 0 && mq.size() > 0), 32'd1);
                if (mq.size() > 0) chk("awaddr", awaddr, {mq[0].addr[31:4], 4'h0});
                chk("awlen", 32'(awlen), 32'd3);
                chk("awsize", 32'(awsize), 32'd2);
                chk("awburst", 32'(awburst), 32'd1);
            end
            if (wvalid && mq.size() > 0) begin
                chk("wdata", wdata, mq[0].data[tb_beat]);
                chk("wlast", 32'(wlast), 32'(tb_beat == 3));
                chk("wstrb", 32'(wstrb), 32'hF);
            end
            if (awvalid && awready && tb_phase == 0) begin
                tb_phase = 1; tb_beat = 0;
            end else if (wvalid && wready && tb_phase == 1) begin
                if (tb_beat == 3) begin
                    tb_phase = 2; tb_beat = 0;
                end else begin
                    tb_beat++;
                end
            end else if (bvalid && bready && tb_phase == 2 && mq.size() > 0) begin
                void'(mq.pop_front());
                tb_phase = 0;
            end
            push_fired = push_valid && push_ready;
            if (push_fired) mq.push_back('{addr: push_addr, data: push_data});
            prev_aw_stall = awvalid && !awready;
            prev_awaddr   = awaddr;
            prev_w_stall  = wvalid && !wready;
            prev_wdata    = wdata;
            prev_wlast    = wlast;
        end
    end

    task automatic push_line(input logic [31:0] a, input DCData_t d);
        int n;
        @(posedge clk); #1;
        push_valid = 1'b1; push_addr = a; push_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!push_ready && n < 300);
        if (n >= 300) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (tb_phase == p) return;
        end
        chk("phase_timeout", 32'(tb_phase), 32'(p));
    endtask

    task automatic wait_empty(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (empty && mq.size() == 0) return;
        end
        chk("drain_timeout", 32'(mq.size()), 32'd0);
    endtask

    task automatic set_ready(input logic aw, input logic w, input logic b);
        @(posedge clk); #1;
        awready = aw; wready = w; bvalid = b;
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bcnt;
        rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        chk_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single line, fully ready slave.
        set_ready(1'b1, 1'b1, 1'b1);
        push_line(32'h8000_1234, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_phase(2, 50);
        @(negedge clk); #1;  // B handshake cycle
        @(negedge clk); @(negedge clk); #1;
        chk("empty_after_b", 32'(empty), 32'd1);

        // Fill to capacity with AW blocked; a third push must stall.
        set_ready(1'b0, 1'b1, 1'b1);
        push_line(32'h8000_2000, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        push_line(32'h8000_3010, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        fork
            push_line(32'h8000_4020, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        join_none
        repeat (5) @(negedge clk);
        #1;
        chk("full_ready", 32'(push_ready), 32'd0);
        chk("stall_held", 32'(push_valid), 32'd1);
        set_ready(1'b1, 1'b1, 1'b1);
        wait fork;
        wait_empty(200);

        // Lookup while the line is mid-burst, then after it retires.
        set_ready(1'b1, 1'b0, 1'b0);
        push_line(32'h8000_1230, {32'h13, 32'h12, 32'h11, 32'h10});
        wait_phase(1, 50);
        @(posedge clk); #1 chk_addr = 32'h8000_123C;
        @(negedge clk); #1 chk("hit_same_line", 32'(chk_hit), 32'd1);
        @(posedge clk); #1 chk_addr = 32'h8000_1240;
        @(negedge clk); #1 chk("miss_next_line", 32'(chk_hit), 32'd0);
        set_ready(1'b1, 1'b1, 1'b1);
        wait_empty(50);
        @(posedge clk); #1 chk_addr = 32'h8000_123C;
        @(negedge clk); #1 chk("miss_after_b", 32'(chk_hit), 32'd0);

        // Data channel toggling ready every cycle.
        set_ready(1'b1, 1'b0, 1'b1);
        push_line(32'h8000_5000, {32'h53, 32'h52, 32'h51, 32'h50});
        for (int i = 0; i < 40 && !(empty && mq.size() == 0); i++) begin
            @(posedge clk); #1 wready = ~wready;
        end
        wait_empty(50);

        // Push landing in the same cycle as the B pop.
        set_ready(1'b1, 1'b1, 1'b0);
        push_line(32'h8000_6000, {32'h63, 32'h62, 32'h61, 32'h60});
        wait_phase(2, 50);
        @(posedge clk); #1;
        bvalid = 1'b1; push_valid = 1'b1;
        push_addr = 32'h8000_7040; push_data = {32'h73, 32'h72, 32'h71, 32'h70};
        @(negedge clk); #1;
        chk("pop_push_fired", 32'(push_fired), 32'd1);
        chk("pop_push_count", 32'(mq.size()), 32'd1);
        @(posedge clk); #1 push_valid = 1'b0;
        @(negedge clk); #1 chk("pop_push_not_empty", 32'(empty), 32'd0);
        wait_empty(50);

        // Reset in the middle of the data beats.
        set_ready(1'b1, 1'b1, 1'b0);
        push_line(32'h8000_8000, {32'h83, 32'h82, 32'h81, 32'h80});
        bcnt = 0;
        while (!(tb_phase == 1 && tb_beat == 2) && bcnt < 50) begin
            @(negedge clk); #1; bcnt++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_awvalid", 32'(awvalid), 32'd0);
        chk("post_rst_wvalid", 32'(wvalid), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_ready", 32'(push_ready), 32'd1);
        set_ready(1'b1, 1'b1, 1'b1);
        push_line(32'h8000_9000, {32'h93, 32'h92, 32'h91, 32'h90});
        wait_empty(50);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
            if (!push_valid || push_fired) begin
                push_valid = ($urandom_range(0, 2) == 0);
                push_addr  = {24'h800000, 4'($urandom_range(0, 7)), 4'($urandom)};
                push_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                chk_addr = {mq[$urandom_range(0, mq.size() - 1)].addr[31:4], 4'($urandom)};
            else
                chk_addr = {24'h800000, 8'($urandom)};
        end
        @(posedge clk); #1 push_valid = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        wait_empty(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dcache_writeback
`default_nettype wire

// File: doc/dcache_writeback.md
DCACHE_WRITEBACK -- requirements
Module: dcache_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of dirty-line entries; legal values 2 or 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports push_valid (in, 1), push_addr (in, 32, line address of evicted line) and push_data (in, DCData_t, 4 words); these carry the DCache dirt_valid/dirt_addr/dirt_data.
REQ-005 SHALL have port push_ready, output, 1, meaning an entry is free.
REQ-006 SHALL have ports chk_addr (in, 32) and chk_hit (out, 1), meaning the refill address matches a buffered or in-flight line.
REQ-007 SHALL have port empty, output, 1, meaning no entries and no burst in flight; used by the MMU for cache-clear fences.
REQ-008 SHALL have AXI3 write ports: awvalid/awready, awaddr 32, awlen 4, awsize 3, awburst 2; wvalid/wready, wdata 32, wstrb 4, wlast; bvalid/bready.

Function
REQ-009 SHALL accept an entry on push_valid && push_ready; push_ready = count < DEPTH, from registered state only, with no same-cycle pop bypass.
REQ-010 SHALL store entries in FIFO order: circular head/tail pointers of log2(DEPTH) bits that wrap, and a count of log2(DEPTH)+1 bits.
REQ-011 SHALL use an FSM with states IDLE, AW, W, B.
  - IDLE -> AW when count > 0.
  - AW -> W on awready.
  - W -> B on wready && wlast.
  - B -> IDLE on bvalid, popping the head.
REQ-012 SHALL raise awvalid at the earliest one cycle after a push into an empty buffer.
REQ-013 SHALL drive awaddr = {head_addr[31:4], 4'b0}, awlen = 4'd3, awsize = 3'b010, awburst = 2'b01 (INCR).
REQ-014 SHALL hold AW signals stable while awvalid && !awready.
REQ-015 SHALL drive wvalid only in W.
  - A 2-bit beat counter starts at 0 and advances on wready.
  - wdata = head word[beat], word 0 first.
  - wstrb = 4'hF.
  - wlast = (beat == 3).
REQ-016 SHALL hold wdata stable while wvalid && !wready.
REQ-017 SHALL drive bready = 1 only in B; bresp is ignored.
REQ-018 SHALL keep the head entry valid and comparable until the B handshake completes.
REQ-019 SHALL compute chk_hit combinationally as OR over valid entries of (entry_addr[31:4] == chk_addr[31:4]).
REQ-020 SHALL let a push and a B-pop in the same cycle both take effect, leaving count unchanged.
REQ-021 SHALL exclude a line pushed in the current cycle from chk_hit until the next cycle.
REQ-022 SHALL drive empty = (count == 0) && state == IDLE.
REQ-023 SHALL treat push_valid while full as stalled, not dropped; the upstream holds it.

Reset
REQ-024 SHALL on rst clear count, pointers, beat counter and all entry valid bits, and enter IDLE, abandoning any burst in flight.
REQ-025 SHALL drive outputs 0 during and after reset, except push_ready = 1 and empty = 1; awlen/awsize/awburst/wstrb are constants.

Structure
REQ-026 SHALL take DCData_t, word_t and line-offset width from the shared DCache package; awlen/awsize/awburst constants belong in the shared AXI package.
REQ-027 SHALL be a single module with no sub-modules; the FIFO storage is inline register arrays.

Verification
REQ-028 Push addr 0x8000_1234, data {W3..W0} = {4,3,2,1}, awready/wready/bvalid always 1 -> awaddr 0x8000_1230, awlen 3, wdata 1,2,3,4, wlast on 4th beat, empty = 1 two cycles after B.
REQ-029 Push 2 lines with DEPTH = 2 and awready held 0 -> push_ready = 0; a 3rd push_valid held stalled; push_ready returns 1 in the cycle after the first B handshake.
REQ-030 chk_addr 0x8000_123C with line 0x8000_1230 in W state -> chk_hit = 1; chk_addr 0x8000_1240 -> chk_hit = 0; after B completes, 0x8000_123C -> 0.
REQ-031 wready toggling 1,0,1,0,... -> wdata/wvalid stable while stalled; exactly 4 beats; no beat skipped.
REQ-032 Push in the same cycle as the B pop with count = 1 -> count stays 1; next AW carries the new line address.
REQ-033 Assert rst during W beat 2 -> next cycle awvalid = wvalid = 0, empty = 1, push_ready = 1, and a following push starts a fresh burst at beat 0.
